// File: rtl/pulse_seq_ctrl.sv
// Pulse-train sequencer: latches high/low lengths and a pulse count on a start edge and plays them out.
// Optional retrigger of a running sequence is enabled by defining PULSE_SEQ_RETRIG_EN.
module pulse_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] pulse_cnt,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_idx
);

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic             start_q_r;
  logic [CNT_W-1:0] h_len_r;
  logic [CNT_W-1:0] l_len_r;
  logic [CNT_W-1:0] n_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic [CNT_W-1:0] idx_nx_s;
  logic [CNT_W-1:0] h_in_s;
  logic [CNT_W-1:0] l_in_s;
  logic             edge_s;
  logic             retrig_s;
  logic             launch_s;

  assign edge_s = start & ~start_q_r;
  assign h_in_s = (high_len == ZERO) ? ONE : high_len;
  assign l_in_s = (low_len == ZERO) ? ONE : low_len;

`ifdef PULSE_SEQ_RETRIG_EN
  assign retrig_s = edge_s & ((state_r == ST_HIGH) | (state_r == ST_LOW));
`else
  assign retrig_s = 1'b0;
`endif

  assign launch_s = (edge_s & (state_r == ST_IDLE)) | retrig_s;

  // Next-state, phase counter and pulse index; cnt_r counts down to zero on the last phase cycle
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    idx_nx_s   = pulse_idx;
    if (launch_s) begin
      idx_nx_s   = ZERO;
      cnt_nx_s   = h_in_s - ONE;
      state_nx_s = (pulse_cnt == ZERO) ? ST_DONE : ST_HIGH;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_IDLE;
        end
        ST_HIGH: begin
          if (cnt_r != ZERO) begin
            cnt_nx_s = cnt_r - ONE;
          end else if (pulse_idx == n_r - ONE) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_LOW;
            cnt_nx_s   = l_len_r - ONE;
          end
        end
        ST_LOW: begin
          if (cnt_r != ZERO) begin
            cnt_nx_s = cnt_r - ONE;
          end else begin
            state_nx_s = ST_HIGH;
            cnt_nx_s   = h_len_r - ONE;
            idx_nx_s   = pulse_idx + ONE;
          end
        end
        ST_DONE: begin
          state_nx_s = ST_IDLE;
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, latched parameters and outputs; outputs decode the next state so they are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      start_q_r <= 1'b0;
      h_len_r   <= ONE;
      l_len_r   <= ONE;
      n_r       <= ZERO;
      cnt_r     <= ZERO;
      pulse_idx <= ZERO;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      start_q_r <= start;
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      pulse_idx <= idx_nx_s;
      if (launch_s) begin
        h_len_r <= h_in_s;
        l_len_r <= l_in_s;
        n_r     <= pulse_cnt;
      end
      pulse_out <= (state_nx_s == ST_HIGH);
      busy      <= (state_nx_s == ST_HIGH) | (state_nx_s == ST_LOW);
      done      <= (state_nx_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Bench for pulse_seq_ctrl: a schedule-queue model checked every cycle, plus directed literal scenarios.
module tb_pulse_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic [7:0] pulse_cnt;
  logic       pulse_out;
  logic       busy;
  logic       done;
  logic [7:0] pulse_idx;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PULSE_SEQ_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  pulse_seq_ctrl #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .high_len  (high_len),
    .low_len   (low_len),
    .pulse_cnt (pulse_cnt),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .pulse_idx (pulse_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected per-cycle outputs: whole sequence is expanded into a queue at launch time
  typedef struct packed {
    logic       p;
    logic       b;
    logic       d;
    logic [7:0] idx;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic prev_start;

  function automatic void build(input int h, input int l, input int n);
    int hh = (h == 0) ? 1 : h;
    int ll = (l == 0) ? 1 : l;
    q.delete();
    if (n == 0) begin
      q.push_back({1'b0, 1'b0, 1'b1, 8'd0});
    end else begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < hh; k++) q.push_back({1'b1, 1'b1, 1'b0, 8'(i)});
        if (i < n - 1)
          for (int k = 0; k < ll; k++) q.push_back({1'b0, 1'b1, 1'b0, 8'(i)});
      end
      q.push_back({1'b0, 1'b0, 1'b1, 8'(n - 1)});
    end
  endfunction

  // Model update on the active edge and comparison on the opposite edge
  initial begin
    logic e;
    cur        = '0;
    prev_start = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        prev_start = 1'b0;
        cur        = '0;
      end else begin
        e          = start & ~prev_start;
        prev_start = start;
        if (e && !cur.b && !cur.d) build(int'(high_len), int'(low_len), int'(pulse_cnt));
        else if (e && cur.b && RETRIG) build(int'(high_len), int'(low_len), int'(pulse_cnt));
        if (q.size() > 0) cur = q.pop_front();
        else cur = {3'b000, cur.idx};
      end
      @(negedge clk);
      chk("model_pulse_out", int'(pulse_out), int'(cur.p));
      chk("model_busy",      int'(busy),      int'(cur.b));
      chk("model_done",      int'(done),      int'(cur.d));
      chk("model_pulse_idx", int'(pulse_idx), int'(cur.idx));
    end
  end

  logic [31:0] pv, bv, dv;
  int          idx5, idx6, npulse, ndone;

  initial begin
    rst = 1'b1; start = 1'b0; high_len = 8'd1; low_len = 8'd1; pulse_cnt = 8'd1;
    tick(); tick();
    chk("reset_pulse_out", int'(pulse_out), 0);
    chk("reset_busy",      int'(busy),      0);
    chk("reset_done",      int'(done),      0);
    chk("reset_idx",       int'(pulse_idx), 0);
    rst = 1'b0;
    tick();

    // H=2 L=3 N=2
    pv = '0; bv = '0; dv = '0;
    high_len = 8'd2; low_len = 8'd3; pulse_cnt = 8'd2; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      pv[k] = pulse_out; bv[k] = busy; dv[k] = done;
      if (k == 5) idx5 = int'(pulse_idx);
      if (k == 6) idx6 = int'(pulse_idx);
    end
    chk("t1_pulse", int'(pv), 32'h0000_00C6);
    chk("t1_busy",  int'(bv), 32'h0000_00FE);
    chk("t1_done",  int'(dv), 32'h0000_0100);
    chk("t1_idx5",  idx5, 0);
    chk("t1_idx6",  idx6, 1);
    start = 1'b0; tick(); tick();

    // zero lengths treated as one
    pv = '0; dv = '0;
    high_len = 8'd0; low_len = 8'd0; pulse_cnt = 8'd3; start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      pv[k] = pulse_out; dv[k] = done;
    end
    chk("t2_pulse", int'(pv), 32'h0000_002A);
    chk("t2_done",  int'(dv), 32'h0000_0040);
    start = 1'b0; tick(); tick();

    // empty sequence
    pv = '0; bv = '0; dv = '0;
    high_len = 8'd3; low_len = 8'd3; pulse_cnt = 8'd0; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      pv[k] = pulse_out; bv[k] = busy; dv[k] = done;
    end
    chk("t3_pulse", int'(pv), 0);
    chk("t3_busy",  int'(bv), 0);
    chk("t3_done",  int'(dv), 32'h0000_0002);
    start = 1'b0; tick(); tick();

    // start held high launches exactly once
    npulse = 0; ndone = 0;
    high_len = 8'd1; low_len = 8'd1; pulse_cnt = 8'd1; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      npulse += int'(pulse_out); ndone += int'(done);
    end
    chk("t4_pulses", npulse, 1);
    chk("t4_dones",  ndone, 1);
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("t4_relaunch", int'(pulse_out), 1);
    start = 1'b0; tick(); tick(); tick();

    // reset mid-sequence
    high_len = 8'd4; low_len = 8'd4; pulse_cnt = 8'd3; start = 1'b1;
    for (int k = 1; k <= 6; k++) tick();
    start = 1'b0; rst = 1'b1;
    tick();
    chk("t5_rst_pulse", int'(pulse_out), 0);
    chk("t5_rst_busy",  int'(busy),      0);
    chk("t5_rst_done",  int'(done),      0);
    chk("t5_rst_idx",   int'(pulse_idx), 0);
    rst = 1'b0; ndone = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      ndone += int'(done);
    end
    chk("t5_no_done", ndone, 0);
    high_len = 8'd1; low_len = 8'd1; pulse_cnt = 8'd1; start = 1'b1;
    tick();
    chk("t5_restart_pulse", int'(pulse_out), 1);
    chk("t5_restart_busy",  int'(busy),      1);
    start = 1'b0; tick(); tick(); tick();

    // edge while running
    pv = '0; dv = '0;
    high_len = 8'd4; low_len = 8'd2; pulse_cnt = 8'd2; start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      pv[k] = pulse_out; dv[k] = done;
      if (k == 1) start = 1'b0;
      if (k == 3) begin
        start = 1'b1; high_len = 8'd1; pulse_cnt = 8'd1;
      end
    end
    if (RETRIG) begin
      chk("t6_pulse_retrig", int'(pv), 32'h0000_001E);
      chk("t6_done_retrig",  int'(dv), 32'h0000_0020);
    end else begin
      chk("t6_pulse_ignore", int'(pv), 32'h0000_079E);
      chk("t6_done_ignore",  int'(dv), 32'h0000_0800);
    end
    start = 1'b0; tick(); tick();

    // randomized traffic, including mid-sequence input changes and occasional resets
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 3) == 0) start = ~start;
      if ($urandom_range(0, 2) == 0) begin
        high_len  = 8'($urandom_range(0, 5));
        low_len   = 8'($urandom_range(0, 5));
        pulse_cnt = 8'($urandom_range(0, 4));
      end
      tick();
    end
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < 60; c++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
